// File: rtl/mmio_ctrl_pkg.sv
// mmio_ctrl_pkg: shared MMIO decode constants and types.
// IoRegion is the addr[31:30] code of the IO window. The Off* constants are the byte offsets of
// the six registers inside that window. The core's control stage uses the same constants.
// Only offset bits [4:2] take part in the decode.
package mmio_ctrl_pkg;

    localparam logic [1:0] IoRegion = 2'b10;

    localparam logic [4:0] OffStatus = 5'h00;
    localparam logic [4:0] OffRxData = 5'h04;
    localparam logic [4:0] OffTxData = 5'h08;
    localparam logic [4:0] OffCycle  = 5'h10;
    localparam logic [4:0] OffInstr  = 5'h14;
    localparam logic [4:0] OffCntClr = 5'h18;

    typedef enum logic {
        TxIdle,
        TxPend
    } tx_state_e;

    function automatic logic is_io(input logic [31:0] addr);
        return addr[31:30] == IoRegion;
    endfunction

    // Register index used by the decoder (word offset inside the IO window).
    function automatic logic [2:0] reg_idx(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// mmio_rx_fifo: receive byte buffer between the UART receiver and the rx data register.
// Depth must be a power of two and at least 2, so the pointers wrap naturally.
// Ports:
//   clk_i    system clock
//   rst      synchronous active-high reset; empties the buffer
//   push_i   write data_i (the caller guarantees !full_o)
//   data_i   byte to store
//   pop_i    drop the head entry (the caller guarantees !empty_o)
//   data_o   head entry
//   full_o   buffer full
//   empty_o  buffer empty
module mmio_rx_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            // A push and pop together leave the count unchanged.
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped IO block with a UART port, a cycle counter and an instruction counter.
// The IO window is addr[31:30] == 2'b10. Registers sit at offsets 0x00 status,
// 0x04 rx data, 0x08 tx data, 0x10 cycle count, 0x14 instruction count and 0x18 counter clear.
// Optional feature: define MMIO_RX_FIFO_EN to put an RX_FIFO_DEPTH-entry receive buffer in front
// of the rx data register. Without it, the rx register reads the UART receiver directly.
// Ports:
//   clk_i           system clock
//   rst             synchronous active-high reset
//   addr_i          data address from the execute stage
//   wdata_i         store data (only [7:0] used)
//   we_i / re_i     store / load strobes, qualified here by the IO-region decode
//   instr_retire_i  one pulse per retired instruction
//   uart_rx_*       receiver byte handshake (ready is an output)
//   uart_tx_*       transmitter byte handshake (ready is an input)
//   rdata_o         registered load result
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic        instr_retire_i,
    input  logic [7:0]  uart_rx_data_i,
    input  logic        uart_rx_valid_i,
    output logic        uart_rx_ready_o,
    output logic [7:0]  uart_tx_data_o,
    output logic        uart_tx_valid_o,
    input  logic        uart_tx_ready_i,
    output logic [31:0] rdata_o
);

    localparam logic [2:0] IdxStatus = reg_idx(OffStatus);
    localparam logic [2:0] IdxRxData = reg_idx(OffRxData);
    localparam logic [2:0] IdxTxData = reg_idx(OffTxData);
    localparam logic [2:0] IdxCycle  = reg_idx(OffCycle);
    localparam logic [2:0] IdxInstr  = reg_idx(OffInstr);
    localparam logic [2:0] IdxCntClr = reg_idx(OffCntClr);

    logic       io_sel;
    logic [2:0] sel;
    logic       rd_io, wr_io;
    logic       cnt_clr, tx_start;

    assign io_sel   = is_io(addr_i);
    assign sel      = addr_i[4:2];
    assign rd_io    = re_i && io_sel;
    assign wr_io    = we_i && io_sel;
    assign cnt_clr  = wr_io && (sel == IdxCntClr);
    assign tx_start = wr_io && (sel == IdxTxData);

    logic        rx_avail;
    logic [7:0]  rx_byte;

    tx_state_e   tx_state_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ins_cnt_q, ins_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_val;

`ifdef MMIO_RX_FIFO_EN
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_data;
    logic       rx_push, rx_pop;

    // Ready depends only on fullness, so a full buffer never sees push and pop together.
    assign uart_rx_ready_o = !rst && !fifo_full;
    assign rx_push         = uart_rx_valid_i && uart_rx_ready_o;
    assign rx_pop          = rd_io && (sel == IdxRxData) && !fifo_empty;
    assign rx_avail        = !fifo_empty;
    assign rx_byte         = fifo_data;

    mmio_rx_fifo #(
        .Depth (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .push_i  (rx_push),
        .data_i  (uart_rx_data_i),
        .pop_i   (rx_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic unused_bits;
    assign unused_bits = ^{addr_i[29:5], addr_i[1:0], wdata_i[31:8]};
`else
    // No buffer: a load of rx data consumes the receiver byte directly, only when one is present.
    assign rx_avail        = uart_rx_valid_i;
    assign rx_byte         = uart_rx_data_i;
    assign uart_rx_ready_o = !rst && rd_io && (sel == IdxRxData) && uart_rx_valid_i;

    logic [31:0] unused_depth;
    logic        unused_bits;
    assign unused_depth = RX_FIFO_DEPTH;
    assign unused_bits  = ^{addr_i[29:5], addr_i[1:0], wdata_i[31:8], unused_depth};
`endif

    // Read mux sees pre-edge state, so a status load shows flags from before this edge.
    always_comb begin
        rd_val = '0;
        unique case (sel)
            IdxStatus: rd_val = {30'b0, rx_avail, tx_state_q == TxIdle};
            IdxRxData: rd_val = rx_avail ? {24'b0, rx_byte} : 32'b0;
            IdxCycle:  rd_val = cyc_cnt_q;
            IdxInstr:  rd_val = ins_cnt_q;
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        rdata_d   = rd_io ? rd_val : rdata_q;
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ins_cnt_d = ins_cnt_q + {31'b0, instr_retire_i};
        // Clear wins over the same-cycle increment.
        if (cnt_clr) begin
            cyc_cnt_d = '0;
            ins_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            rdata_q   <= '0;
            cyc_cnt_q <= '0;
            ins_cnt_q <= '0;
        end else begin
            rdata_q   <= rdata_d;
            cyc_cnt_q <= cyc_cnt_d;
            ins_cnt_q <= ins_cnt_d;
        end
    end

    // TX FSM: a store while pending is dropped; the byte is held until the handshake.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_start) begin
                        tx_state_q <= TxPend;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= wdata_i[7:0];
                    end
                end
                TxPend: begin
                    if (uart_tx_ready_i) begin
                        tx_state_q <= TxIdle;
                        tx_valid_q <= 1'b0;
                    end
                end
                default: begin
                    tx_state_q <= TxIdle;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign uart_tx_valid_o = tx_valid_q;
    assign uart_tx_data_o  = tx_data_q;
    assign rdata_o         = rdata_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
module tb_mmio_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        we, re, retire, rxv, txr;
    logic [7:0]  rxd;
    logic        rxr, txv;
    logic [7:0]  txd;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    mmio_ctrl #(
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst             (rst),
        .addr_i          (addr),
        .wdata_i         (wdata),
        .we_i            (we),
        .re_i            (re),
        .instr_retire_i  (retire),
        .uart_rx_data_i  (rxd),
        .uart_rx_valid_i (rxv),
        .uart_rx_ready_o (rxr),
        .uart_tx_data_o  (txd),
        .uart_tx_valid_o (txv),
        .uart_tx_ready_i (txr),
        .rdata_o         (rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] m_cyc, m_ins, m_rdata;
    logic        m_txp;
    logic [7:0]  m_txd;
    logic [7:0]  m_q[$];
    logic        obs_rxr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_avail();
`ifdef MMIO_RX_FIFO_EN
        return m_q.size() != 0;
`else
        return rxv;
`endif
    endfunction

    function automatic logic [7:0] m_byte();
`ifdef MMIO_RX_FIFO_EN
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
`else
        return rxd;
`endif
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return {30'b0, m_avail(), !m_txp};
            3'd1:    return m_avail() ? {24'b0, m_byte()} : 32'b0;
            3'd4:    return m_cyc;
            3'd5:    return m_ins;
            default: return 32'b0;
        endcase
    endfunction

    // One clock: called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        logic       io;
        logic [2:0] idx;
        logic       exp_rxr, do_pop, do_push;
        logic [31:0] val;
        io  = (addr[31:30] == 2'b10);
        idx = addr[4:2];
        #2;
`ifdef MMIO_RX_FIFO_EN
        exp_rxr = !rst && (m_q.size() < DEPTH);
`else
        exp_rxr = !rst && re && io && (idx == 3'd1) && rxv;
`endif
        obs_rxr = rxr;
        chk("rx_ready", {31'b0, rxr}, {31'b0, exp_rxr});
        val     = m_read(idx);
        do_pop  = re && io && (idx == 3'd1) && (m_q.size() != 0);
        do_push = rxv && (m_q.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_ins = 0; m_rdata = 0; m_txp = 0; m_txd = 0;
            m_q.delete();
        end else begin
            if (re && io) m_rdata = val;
            if (we && io && idx == 3'd6) begin
                m_cyc = 0; m_ins = 0;
            end else begin
                m_cyc = m_cyc + 1;
                if (retire) m_ins = m_ins + 1;
            end
            if (m_txp) begin
                if (txr) m_txp = 0;
            end else if (we && io && idx == 3'd2) begin
                m_txp = 1;
                m_txd = wdata[7:0];
            end
`ifdef MMIO_RX_FIFO_EN
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(rxd);
`endif
        end
        #1;
        chk("rdata", rdata, m_rdata);
        chk("tx_valid", {31'b0, txv}, {31'b0, m_txp});
        chk("tx_data", {24'b0, txd}, {24'b0, m_txd});
    endtask

    task automatic idle();
        addr = 32'h0; wdata = 32'h0; we = 0; re = 0; retire = 0;
    endtask

    task automatic load(input logic [31:0] a);
        idle(); addr = a; re = 1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        idle(); addr = a; wdata = d; we = 1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); rst = 0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we, re, ret, txr, rxv;
        logic [7:0]  rxd;
        logic [31:0] e_rdata;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_rxr;
        logic        rx_dep;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic w,
                                input logic r, input logic rt, input logic tr, input logic rv,
                                input logic [7:0] rb, input logic [31:0] er, input logic et,
                                input logic [7:0] ed, input logic erx, input logic dep);
        vec_t v;
        v.addr = a; v.wdata = d; v.we = w; v.re = r; v.ret = rt; v.txr = tr; v.rxv = rv;
        v.rxd = rb; v.e_rdata = er; v.e_txv = et; v.e_txd = ed; v.e_rxr = erx; v.rx_dep = dep;
        return v;
    endfunction

    vec_t tbl[20];
    logic [31:0] r;
    int          cnt;

    initial begin
        rst = 1; idle(); txr = 0; rxv = 0; rxd = 0;
        m_cyc = 0; m_ins = 0; m_rdata = 0; m_txp = 0; m_txd = 0;

        //           addr          wdata   we re rt tr rv rxd    rdata  txv txd   rxr dep
        tbl[0]  = mk(32'h80000000, 0,      0, 1, 0, 0, 0, 8'h00, 32'h1, 0, 8'h00, 0, 0);
        tbl[1]  = mk(32'h80000000, 0,      0, 1, 0, 0, 1, 8'h5A, 32'h3, 0, 8'h00, 0, 1);
        tbl[2]  = mk(32'h80000004, 0,      0, 1, 0, 0, 1, 8'h5A, 32'h5A, 0, 8'h00, 1, 1);
        tbl[3]  = mk(32'h80000004, 0,      0, 1, 0, 0, 0, 8'h00, 32'h0, 0, 8'h00, 0, 1);
        tbl[4]  = mk(32'h80000008, 32'h141, 1, 0, 0, 0, 0, 8'h00, 32'h0, 1, 8'h41, 0, 1);
        tbl[5]  = mk(32'h00000000, 0,      0, 0, 0, 0, 0, 8'h00, 32'h0, 1, 8'h41, 0, 1);
        tbl[6]  = mk(32'h80000008, 32'h42, 1, 0, 0, 0, 0, 8'h00, 32'h0, 1, 8'h41, 0, 1);
        tbl[7]  = mk(32'h80000000, 0,      0, 1, 0, 0, 1, 8'h33, 32'h2, 1, 8'h41, 0, 1);
        tbl[8]  = mk(32'h00000000, 0,      0, 0, 0, 1, 0, 8'h00, 32'h2, 0, 8'h41, 0, 1);
        tbl[9]  = mk(32'h80000000, 0,      0, 1, 0, 0, 0, 8'h00, 32'h1, 0, 8'h41, 0, 1);
        tbl[10] = mk(32'h00000008, 32'h55, 1, 1, 0, 0, 0, 8'h00, 32'h1, 0, 8'h41, 0, 1);
        tbl[11] = mk(32'h8000000C, 0,      0, 1, 0, 0, 0, 8'h00, 32'h0, 0, 8'h41, 0, 0);
        tbl[12] = mk(32'h80000018, 32'h9,  1, 0, 0, 0, 0, 8'h00, 32'h0, 0, 8'h41, 0, 0);
        tbl[13] = mk(32'h80000010, 0,      0, 1, 1, 0, 0, 8'h00, 32'h0, 0, 8'h41, 0, 0);
        tbl[14] = mk(32'h80000014, 0,      0, 1, 0, 0, 0, 8'h00, 32'h1, 0, 8'h41, 0, 0);
        tbl[15] = mk(32'h80000010, 0,      0, 1, 0, 0, 0, 8'h00, 32'h2, 0, 8'h41, 0, 0);
        tbl[16] = mk(32'hBFFFFFF0, 0,      0, 1, 0, 0, 0, 8'h00, 32'h3, 0, 8'h41, 0, 0);
        tbl[17] = mk(32'h80000018, 0,      1, 0, 1, 0, 0, 8'h00, 32'h3, 0, 8'h41, 0, 0);
        tbl[18] = mk(32'h80000014, 0,      0, 1, 0, 0, 0, 8'h00, 32'h0, 0, 8'h41, 0, 0);
        tbl[19] = mk(32'h80000010, 0,      0, 1, 0, 0, 0, 8'h00, 32'h1, 0, 8'h41, 0, 0);

        @(posedge clk); #1;
        do_reset();
        foreach (tbl[i]) begin
            addr = tbl[i].addr; wdata = tbl[i].wdata; we = tbl[i].we; re = tbl[i].re;
            retire = tbl[i].ret; txr = tbl[i].txr; rxv = tbl[i].rxv; rxd = tbl[i].rxd;
            cycle();
`ifdef MMIO_RX_FIFO_EN
            if (!tbl[i].rx_dep) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rdata);
`else
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_rxr", i), {31'b0, obs_rxr}, {31'b0, tbl[i].e_rxr});
`endif
            chk($sformatf("tbl%0d_txv", i), {31'b0, txv}, {31'b0, tbl[i].e_txv});
            chk($sformatf("tbl%0d_txd", i), {24'b0, txd}, {24'b0, tbl[i].e_txd});
        end
        txr = 0; rxv = 0;

        // Counter after reset plus 100 idle cycles; zero pipeline offset.
        do_reset();
        idle();
        repeat (100) cycle();
        load(32'h80000010); cycle();
        chk("cycle_after_100", rdata, 32'd100);
        load(32'h80000014); cycle();
        chk("instr_after_reset", rdata, 32'd0);

        // TX: ready held low for 5 valid cycles, second store dropped.
        store(32'h80000008, 32'h41); cycle();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!txv) break;
            cnt++;
            chk("tx_hold_data", {24'b0, txd}, 32'h41);
            if (cnt == 2) store(32'h80000008, 32'h42);
            else idle();
            txr = (cnt > 5);
            cycle();
        end
        chk("tx_valid_cycles", cnt, 32'd6);
        txr = 0;

`ifndef MMIO_RX_FIFO_EN
        // RX without buffer: one ready pulse per load.
        rxv = 1; rxd = 8'h5A;
        load(32'h80000000); cycle();
        chk("rx_status", rdata, 32'h3);
        load(32'h80000004); cycle();
        cnt = obs_rxr;
        chk("rx_byte", rdata, 32'h5A);
        idle(); cycle(); cnt += obs_rxr;
        cycle(); cnt += obs_rxr;
        chk("rx_ready_pulses", cnt, 32'd1);
        rxv = 0;
`endif

        // Counter wrap, then clear beating a same-cycle retire.
        idle();
        dut.cyc_cnt_q <= 32'hFFFF_FFFE;
        m_cyc = 32'hFFFF_FFFE;
        repeat (3) cycle();
        load(32'h80000010); cycle();
        chk("cycle_wrap", rdata, 32'h1);
        idle(); retire = 1; cycle();
        store(32'h80000018, 32'h0); retire = 1; cycle();
        load(32'h80000014); cycle();
        chk("clear_vs_retire_instr", rdata, 32'h0);
        load(32'h80000010); cycle();
        chk("clear_cycle", rdata, 32'h1);

        // Reset during PEND abandons the byte; rx_ready low while in reset.
        store(32'h80000008, 32'h77); cycle();
        idle(); cycle();
        chk("pend_before_rst", {31'b0, txv}, 32'h1);
        load(32'h80000004); rxv = 1; rxd = 8'hA5; rst = 1; cycle();
        chk("rxr_in_rst", {31'b0, obs_rxr}, 32'h0);
        chk("txv_after_rst", {31'b0, txv}, 32'h0);
        rst = 0; rxv = 0;
        load(32'h80000010); cycle();
        chk("cycle_after_rst", rdata, 32'h0);
        load(32'h80000000); cycle();
        chk("tx_free_after_rst", rdata, 32'h1);
        chk("txv_stays_low", {31'b0, txv}, 32'h0);

`ifdef MMIO_RX_FIFO_EN
        // Buffer fills after DEPTH bytes, drains in order, then takes the waiting byte.
        do_reset();
        idle(); rxv = 1;
        for (int b = 1; b <= 4; b++) begin
            rxd = 8'(b); cycle();
            chk("fifo_accept", {31'b0, obs_rxr}, 32'h1);
        end
        rxd = 8'h05; cycle();
        chk("fifo_full_ready", {31'b0, obs_rxr}, 32'h0);
        load(32'h80000004); cycle();
        chk("fifo_pop1", rdata, 32'h1);
        load(32'h80000004); cycle();
        chk("fifo_accept5", {31'b0, obs_rxr}, 32'h1);
        chk("fifo_pop2", rdata, 32'h2);
        rxv = 0;
        for (int b = 3; b <= 5; b++) begin
            load(32'h80000004); cycle();
            chk("fifo_pop", rdata, 32'(b));
        end
        load(32'h80000004); cycle();
        chk("fifo_empty_read", rdata, 32'h0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom();
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) != 0)
                addr = {2'b10, r[29:5], 3'($urandom_range(0, 7)), r[1:0]};
            else
                addr = {1'b0, r[30:0]};
            wdata  = $urandom();
            we     = ($urandom_range(0, 3) == 0);
            re     = ($urandom_range(0, 1) == 0);
            retire = ($urandom_range(0, 1) == 0);
            txr    = ($urandom_range(0, 2) == 0);
            rxv    = ($urandom_range(0, 1) == 0);
            rxd    = 8'($urandom());
            cycle();
        end
        rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
